wir_ctrl: RTL and testbench
===========================

// Module: wir_ctrl
// PURPOSE
//  IEEE 1500 Wrapper Instruction Register (WIR) and wrapper serial-control decoder.
//  Shifts and updates the wrapper instruction from the WSC port. Drives the per-cycle
//  scan/hold enables for the WBR input and output cell chains (wse_inputs/hold_inputs,
//  wse_outputs/hold_outputs). Muxes the serial output from WIR, bypass or WBR.
//  Sits directly upstream of every WBR cell; all cells share CLK with this block.
// PARAMETERS
//  IR_W        3       WIR width in bits (>=2)
//  IR_CAPTURE  3'b001  value loaded into WIR shift stage on capture_wr with select_wir=1
// PORTS
//  CLK           in   1     wrapper clock; all state updates on rising edge
//  RESET         in   1     asynchronous, active-high reset
//  select_wir    in   1     1: WSC ops target the WIR; 0: WSC ops target the selected data register
//  shift_wr      in   1     shift operation this cycle
//  capture_wr    in   1     capture operation this cycle
//  update_wr     in   1     update operation this cycle
//  wsi           in   1     wrapper serial input
//  wbr_so        in   1     serial out of the last WBR cell (its CTO)
//  wso           out  1     wrapper serial output
//  wse_inputs    out  1     scan enable, input-cell chain (1 = take CTI)
//  hold_inputs   out  1     hold, input cells (1 = recirculate CTO; 0 = capture CFI)
//  wse_outputs   out  1     scan enable, output-cell chain
//  hold_outputs  out  1     hold, output cells
//  wbr_sel       out  1     WBR is the active data register
//  instr         out  IR_W  current (updated) instruction
//  proto_err     out  1     sticky: illegal simultaneous WSC operations seen
// BEHAVIOUR
//  Reset (async, immediate): shift stage=0, instr=WS_BYPASS(0), bypass bit=0, proto_err=0.
//   Outputs while RESET=1: wse_*=0, hold_*=1, wbr_sel=0.
//  Opcodes: 0 WS_BYPASS; 1 WS_EXTEST (input cells active); 2 WS_INTEST (output cells
//   active); 3 WS_SAMPLE (both chains active). All others decode as WS_BYPASS.
//  op_ok = exactly one of shift_wr/capture_wr/update_wr, or none (idle).
//   If two or more are high: no register changes, all enables behave as idle, and
//   proto_err sets on that edge. It stays set until RESET.
//  WIR path (select_wir=1, op_ok):
//   - capture: shift stage <= IR_CAPTURE.
//   - shift: shift stage <= {wsi, stage[IR_W-1:1]} (LSB first out).
//   - update: instr <= shift stage. The new instr is visible on the next cycle.
//   - wse_*=0 and hold_*=1 throughout, so WBR cells never move during WIR access.
//  Data path (select_wir=0, op_ok):
//   - wbr_sel = (instr is EXTEST/INTEST/SAMPLE). Otherwise the 1-bit bypass register is used.
//   - Bypass capture: bypass <= 0. Bypass shift: bypass <= wsi.
//   - Active chain = input chain (EXTEST/SAMPLE) or output chain (INTEST/SAMPLE).
//   - wse_x  = shift_wr & wbr_sel. Both chains shift whenever WBR is selected, to keep
//     the chain unbroken.
//   - hold_x = ~((capture_wr & chain x active) | (shift_wr & wbr_sel)).
//   - Idle or update: wse_*=0, hold_*=1 (cells keep state).
//  wse_*/hold_*/wbr_sel are combinational from the current WSC inputs and registered
//   instr. They are sampled by the cells on the same CLK edge: zero-cycle latency.
//  wso: select_wir ? stage[0] : (wbr_sel ? wbr_so : bypass). Combinational, no retiming.
//  instr only changes on a legal WIR update, never mid-shift.
//  RESET during any operation aborts it and forces the reset state.
// TESTING
//  1. Release reset, idle 3 cycles -> instr=0, hold_inputs=hold_outputs=1, wse_*=0, proto_err=0.
//  2. select_wir=1; capture, then shift 3 cycles with wsi=1,0,0; then update.
//     Expected: wso=1,0,0 during the shift; instr=3'b001 on the cycle after update.
//  3. Load EXTEST; select_wir=0; capture -> hold_inputs=0 and hold_outputs=1 that cycle.
//     Then shift 4 cycles -> wse_inputs=wse_outputs=1, hold_*=0, wso follows wbr_so.
//  4. instr=BYPASS, select_wir=0; capture, then shift wsi=1,1.
//     Expected: wso=0 then 1; wbr_sel=0; hold_*=1 throughout.
//  5. Assert shift_wr and update_wr together with select_wir=1.
//     Expected: WIR and instr unchanged; proto_err=1 next cycle and held until RESET.
//  6. Assert RESET mid WIR-shift with instr=INTEST.
//     Expected: instr=0, shift stage=0 and hold_*=1 immediately, without waiting for a CLK edge.

Source files
------------

// File: rtl/wir_ctrl.sv
// wir_ctrl -- IEEE 1500 wrapper instruction register and serial-control decoder.
//
// Holds the wrapper instruction register. It has a shift stage and an update
// stage. It decodes the WSC operations into per-cycle scan and hold enables for
// the input-cell and output-cell chains of the WBR. It also selects which
// register (WIR, bypass or WBR) drives the wrapper serial output.
//
// Ports
//   CLK           wrapper clock, rising edge
//   RESET         asynchronous active-high reset
//   select_wir    1: WSC operations target the WIR; 0: the selected data register
//   shift_wr      shift operation this cycle
//   capture_wr    capture operation this cycle
//   update_wr     update operation this cycle
//   wsi           wrapper serial input
//   wbr_so        serial output of the last WBR cell
//   wso           wrapper serial output
//   wse_inputs    scan enable, input-cell chain
//   hold_inputs   hold, input-cell chain (0 = capture CFI)
//   wse_outputs   scan enable, output-cell chain
//   hold_outputs  hold, output-cell chain
//   wbr_sel       WBR is the active data register
//   instr         current (updated) instruction
//   proto_err     sticky flag: illegal simultaneous WSC operations seen
module wir_ctrl #(
  parameter int              IR_W       = 3,
  parameter logic [IR_W-1:0] IR_CAPTURE = IR_W'(1)
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            select_wir,
  input  logic            shift_wr,
  input  logic            capture_wr,
  input  logic            update_wr,
  input  logic            wsi,
  input  logic            wbr_so,
  output logic            wso,
  output logic            wse_inputs,
  output logic            hold_inputs,
  output logic            wse_outputs,
  output logic            hold_outputs,
  output logic            wbr_sel,
  output logic [IR_W-1:0] instr,
  output logic            proto_err
);

  localparam logic [IR_W-1:0] WS_BYPASS = IR_W'(0);
  localparam logic [IR_W-1:0] WS_EXTEST = IR_W'(1);
  localparam logic [IR_W-1:0] WS_INTEST = IR_W'(2);
  localparam logic [IR_W-1:0] WS_SAMPLE = IR_W'(3);

  logic [IR_W-1:0] stage_reg;
  logic [IR_W-1:0] instr_reg;
  logic            bypass_reg;
  logic            proto_err_reg;

  logic op_ok;
  logic in_active;
  logic out_active;
  logic wbr_dr;
  logic dr_ok;
  logic scan;

  // Decode of the current instruction and WSC operation.
  always_comb begin
    in_active  = 1'b0;
    out_active = 1'b0;
    case (instr_reg)
      WS_EXTEST: in_active = 1'b1;
      WS_INTEST: out_active = 1'b1;
      WS_SAMPLE: begin
        in_active  = 1'b1;
        out_active = 1'b1;
      end
      default: begin
        in_active  = 1'b0;
        out_active = 1'b0;
      end
    endcase

    // More than one operation at a time is illegal. It is treated as idle.
    op_ok  = ~((shift_wr & capture_wr) | (shift_wr & update_wr) | (capture_wr & update_wr));
    wbr_dr = in_active | out_active;

    // The WBR cells move only on a legal data-register operation. RESET forces
    // the cells to hold state without waiting for a clock edge.
    dr_ok = op_ok & ~select_wir & ~RESET;

    // Both chains shift whenever the WBR is selected, so the chain stays unbroken.
    scan = dr_ok & shift_wr & wbr_dr;

    wse_inputs   = scan;
    wse_outputs  = scan;
    hold_inputs  = ~((dr_ok & capture_wr & in_active) | scan);
    hold_outputs = ~((dr_ok & capture_wr & out_active) | scan);
    wbr_sel      = wbr_dr & ~RESET;

    wso = select_wir ? stage_reg[0] : (wbr_sel ? wbr_so : bypass_reg);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stage_reg     <= '0;
      instr_reg     <= WS_BYPASS;
      bypass_reg    <= 1'b0;
      proto_err_reg <= 1'b0;
    end else if (!op_ok) begin
      proto_err_reg <= 1'b1;
    end else if (select_wir) begin
      if (capture_wr) begin
        stage_reg <= IR_CAPTURE;
      end else if (shift_wr) begin
        // Shift toward the LSB, so the LSB leaves first on wso.
        stage_reg <= {wsi, stage_reg[IR_W-1:1]};
      end else if (update_wr) begin
        instr_reg <= stage_reg;
      end
    end else if (!wbr_dr) begin
      if (capture_wr) begin
        bypass_reg <= 1'b0;
      end else if (shift_wr) begin
        bypass_reg <= wsi;
      end
    end
  end

  assign instr     = instr_reg;
  assign proto_err = proto_err_reg;

endmodule

// File: tb/tb_wir_ctrl.sv
// tb_wir_ctrl -- directed, scoreboard-based bench for wir_ctrl.
// Expected values are pushed when stimulus is driven, then popped and compared
// once the DUT output has settled.
module tb_wir_ctrl;

  localparam int       IR_W = 3;
  localparam logic [2:0] CAP = 3'b001;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       select_wir = 1'b0;
  logic       shift_wr = 1'b0;
  logic       capture_wr = 1'b0;
  logic       update_wr = 1'b0;
  logic       wsi = 1'b0;
  logic       wbr_so = 1'b0;
  logic       wso;
  logic       wse_inputs;
  logic       hold_inputs;
  logic       wse_outputs;
  logic       hold_outputs;
  logic       wbr_sel;
  logic [2:0] instr;
  logic       proto_err;

  wir_ctrl #(.IR_W(IR_W), .IR_CAPTURE(CAP)) dut (
    .CLK(CLK), .RESET(RESET), .select_wir(select_wir), .shift_wr(shift_wr),
    .capture_wr(capture_wr), .update_wr(update_wr), .wsi(wsi), .wbr_so(wbr_so),
    .wso(wso), .wse_inputs(wse_inputs), .hold_inputs(hold_inputs),
    .wse_outputs(wse_outputs), .hold_outputs(hold_outputs), .wbr_sel(wbr_sel),
    .instr(instr), .proto_err(proto_err)
  );

  always #5 CLK = ~CLK;

  string      tag_q[$];
  logic [7:0] exp_q[$];
  int         errors = 0;
  int         checks = 0;
  logic [2:0] cur_instr = 3'd0;

  task automatic push(input string tag, input logic [7:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic pop_check(input logic [7:0] obs);
    string      t;
    logic [7:0] e;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0h expected=entry", obs);
      return;
    end
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
    end
  endtask

  // Control bundle: {wse_inputs, hold_inputs, wse_outputs, hold_outputs, wbr_sel}
  function automatic logic [7:0] ctl();
    return {3'b000, wse_inputs, hold_inputs, wse_outputs, hold_outputs, wbr_sel};
  endfunction

  function automatic logic [7:0] exp_ctl(input logic wi, input logic hi, input logic wo,
                                         input logic ho, input logic ws);
    return {3'b000, wi, hi, wo, ho, ws};
  endfunction

  function automatic logic ws_of(input logic [2:0] c);
    return (c == 3'd1) || (c == 3'd2) || (c == 3'd3);
  endfunction

  task automatic drive(input logic sw, input logic sh, input logic ca, input logic up,
                       input logic d);
    @(negedge CLK);
    select_wir = sw;
    shift_wr   = sh;
    capture_wr = ca;
    update_wr  = up;
    wsi        = d;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Capture, shift the opcode LSB first, then update. The capture value leaves wso first.
  task automatic load_instr(input logic [2:0] code);
    drive(1, 0, 1, 0, 0);
    push("wir_capture_ctl", exp_ctl(0, 1, 0, 1, ws_of(cur_instr)));
    #1 pop_check(ctl());
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, code[i]);
      push("wir_shift_wso", {7'd0, CAP[i]});
      push("wir_shift_ctl", exp_ctl(0, 1, 0, 1, ws_of(cur_instr)));
      #1 pop_check({7'd0, wso});
      pop_check(ctl());
      tick();
    end
    drive(1, 0, 0, 1, 0);
    push("instr_before_update", {5'd0, cur_instr});
    #1 pop_check({5'd0, instr});
    tick();
    push("instr_after_update", {5'd0, code});
    pop_check({5'd0, instr});
    cur_instr = code;
    drive(1, 0, 0, 0, 0);
  endtask

  logic [2:0] codes [4];
  logic       b;

  initial begin
    codes[0] = 3'd1; codes[1] = 3'd2; codes[2] = 3'd3; codes[3] = 3'd5;

    // Reset state while RESET is high
    #2;
    push("rst_ctl", exp_ctl(0, 1, 0, 1, 0));
    push("rst_instr", 8'd0);
    push("rst_proto", 8'd0);
    pop_check(ctl());
    pop_check({5'd0, instr});
    pop_check({7'd0, proto_err});

    // 1. release reset and idle
    @(negedge CLK);
    RESET = 1'b0;
    repeat (3) tick();
    push("idle_ctl", exp_ctl(0, 1, 0, 1, 0));
    push("idle_instr", 8'd0);
    push("idle_proto", 8'd0);
    pop_check(ctl());
    pop_check({5'd0, instr});
    pop_check({7'd0, proto_err});

    // 2 and 3. load each instruction, then capture and shift the data register
    for (int k = 0; k < 4; k++) begin
      load_instr(codes[k]);
      drive(0, 0, 1, 0, 0);
      push("dr_capture_ctl", exp_ctl(0,
           ~(codes[k] == 3'd1 || codes[k] == 3'd3), 0,
           ~(codes[k] == 3'd2 || codes[k] == 3'd3), ws_of(codes[k])));
      #1 pop_check(ctl());
      tick();
      for (int i = 0; i < 4; i++) begin
        drive(0, 1, 0, 0, 1'($urandom_range(1)));
        wbr_so = 1'($urandom_range(1));
        if (ws_of(codes[k])) begin
          push("dr_shift_ctl", exp_ctl(1, 0, 1, 0, 1));
          push("dr_shift_wso", {7'd0, wbr_so});
          #1 pop_check(ctl());
          pop_check({7'd0, wso});
        end else begin
          push("dr_shift_bypass_ctl", exp_ctl(0, 1, 0, 1, 0));
          #1 pop_check(ctl());
        end
        tick();
      end
      drive(0, 0, 0, 1, 0);
      push("dr_update_ctl", exp_ctl(0, 1, 0, 1, ws_of(codes[k])));
      #1 pop_check(ctl());
      tick();
      push("dr_update_instr", {5'd0, codes[k]});
      pop_check({5'd0, instr});
    end

    // 4. bypass register: preload 1, capture clears it, then shift 1,1
    load_instr(3'd0);
    drive(0, 1, 0, 0, 1);
    tick();
    drive(0, 0, 1, 0, 0);
    push("byp_pre_capture_wso", 8'd1);
    #1 pop_check({7'd0, wso});
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 0, 1);
      wbr_so = 1'b1;
      push("byp_shift_wso", (i == 0) ? 8'd0 : 8'd1);
      push("byp_shift_ctl", exp_ctl(0, 1, 0, 1, 0));
      #1 pop_check({7'd0, wso});
      pop_check(ctl());
      tick();
    end

    // 5. illegal shift+update on the WIR with instr=INTEST
    load_instr(3'd2);
    drive(1, 0, 1, 0, 0);
    tick();
    drive(1, 1, 0, 1, 0);
    push("illegal_ctl", exp_ctl(0, 1, 0, 1, 1));
    push("illegal_proto_before", 8'd0);
    #1 pop_check(ctl());
    pop_check({7'd0, proto_err});
    tick();
    push("illegal_proto_after", 8'd1);
    push("illegal_instr", 8'd2);
    push("illegal_stage_wso", 8'd1);
    pop_check({7'd0, proto_err});
    pop_check({5'd0, instr});
    pop_check({7'd0, wso});
    drive(0, 1, 1, 0, 1);
    wbr_so = 1'b0;
    push("illegal_dr_ctl", exp_ctl(0, 1, 0, 1, 1));
    #1 pop_check(ctl());
    tick();
    drive(1, 0, 0, 0, 0);
    repeat (2) tick();
    push("proto_sticky", 8'd1);
    push("proto_sticky_wso", 8'd1);
    pop_check({7'd0, proto_err});
    pop_check({7'd0, wso});

    // 6. async RESET in the middle of a WIR shift, instr=INTEST
    drive(1, 1, 0, 0, 1);
    #2;
    b = wso;
    push("pre_reset_wso", 8'd1);
    pop_check({7'd0, b});
    RESET = 1'b1;
    #1;
    push("async_rst_instr", 8'd0);
    push("async_rst_wso", 8'd0);
    push("async_rst_proto", 8'd0);
    push("async_rst_ctl", exp_ctl(0, 1, 0, 1, 0));
    pop_check({5'd0, instr});
    pop_check({7'd0, wso});
    pop_check({7'd0, proto_err});
    pop_check(ctl());
    tick();
    push("rst_hold_wso", 8'd0);
    pop_check({7'd0, wso});
    drive(1, 0, 0, 0, 0);
    RESET = 1'b0;
    tick();
    push("post_rst_instr", 8'd0);
    push("post_rst_wso", 8'd0);
    pop_check({5'd0, instr});
    pop_check({7'd0, wso});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
